// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/response bundle between the execute controller and the M-unit
// Signals:
//   start, flush      controller -> unit   request and pipeline-flush abort
//   Funct3            controller -> unit   M-op select (MUL..REMU)
//   SrcA, SrcB        controller -> unit   rs1 / rs2 operands
//   busy, done, stall unit -> controller   status, one-cycle completion pulse, hold request
//   Result            unit -> controller   registered result, held until the next done
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] Result;

  modport master (
    output start, flush, Funct3, SrcA, SrcB,
    input  busy, done, stall, Result
  );

  modport slave (
    input  start, flush, Funct3, SrcA, SrcB,
    output busy, done, stall, Result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer (shift-add / restoring divide)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_sequencer_if.slave: start/flush/Funct3/SrcA/SrcB in, busy/done/stall/Result out
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]         state;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]      cnt;
  logic               res_neg;
  logic               div0;
  logic               ovf;
  logic [WIDTH-1:0]   result_q;

  // Operand conditioning (evaluated while in PREP from the captured operands)
  logic             a_signed;
  logic             b_signed;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             ovf_det;

  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sa       = a_signed && a_q[WIDTH-1];
    sb       = b_signed && b_q[WIDTH-1];
    abs_a    = sa ? -a_q : a_q;
    abs_b    = sb ? -b_q : b_q;
    // Only DIV and REM (signed) can overflow
    ovf_det  = op[2] && !op[0] && (a_q == MIN_NEG) && (&b_q);
  end

  // One iteration of either algorithm. Multiplication is commutative, so the
  // magnitude of SrcA is walked bit-by-bit from the low half while |SrcB| is added.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   sub_w;
  logic [2*WIDTH-1:0] calc_next;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    // Shifted partial remainder keeps the bit that would fall off the top
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    ge      = rem_sh >= {1'b0, opb};
    // When ge holds the true difference is below the divisor, so WIDTH bits suffice
    sub_w   = rem_sh[WIDTH-1:0] - opb;
    if (op[2]) begin
      calc_next = {(ge ? sub_w : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else begin
      calc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up, word selection and RISC-V special cases
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    prod = res_neg ? -acc : acc;
    quo  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = res_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op)
      3'b000:                 fix_val = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101: begin
        if (div0)      fix_val = {WIDTH{1'b1}};
        else if (ovf)  fix_val = MIN_NEG;
        else           fix_val = quo;
      end
      default: begin
        if (div0)      fix_val = a_q;
        else if (ovf)  fix_val = {WIDTH{1'b0}};
        else           fix_val = rem;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op       <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_neg  <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            op    <= bus.Funct3;
            a_q   <= bus.SrcA;
            b_q   <= bus.SrcB;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            opb     <= abs_b;
            acc     <= {{WIDTH{1'b0}}, abs_a};
            cnt     <= CW'(WIDTH - 1);
            // Remainder takes the dividend's sign; everything else is sign(A)^sign(B)
            res_neg <= (op[2] && op[1]) ? sa : (sa ^ sb);
            div0    <= ~|b_q;
            ovf     <= ovf_det;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            acc <= calc_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            result_q <= fix_val;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  // Raised combinationally in the request cycle so the pipeline holds immediately
  assign bus.stall  = bus.busy || ((state == S_IDLE) && bus.start && !bus.flush);
  assign bus.done   = (state == S_DONE);
  assign bus.Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam int W   = 32;
  localparam int LAT = W + 2;  // edges from the accepting edge to the edge that enters DONE

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    int           acc;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
  } vec_t;

  vec_t vecs[15] = '{
    '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},  // MUL 7*-3
    '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780},  // MUL low word
    '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},  // MULH -1*-1
    '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},  // MULH min*min
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},  // MULHU
    '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},  // MULHSU -1*2
    '{3'b101, 32'd100,       32'd7,         32'd14},         // DIVU
    '{3'b111, 32'd100,       32'd7,         32'd2},          // REMU
    '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},  // DIV -7/2
    '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},  // REM -7%2
    '{3'b100, 32'hFFFF_FFAB, 32'h0000_0000, 32'hFFFF_FFFF},  // DIV by zero, negative dividend
    '{3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234},  // REM by zero
    '{3'b111, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009},  // REMU by zero
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},  // DIV overflow
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}   // REM overflow
  };

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (q.size() == 0) begin
        check("spurious_done", {31'b0, bus.done}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", bus.Result, e.res);
        check("latency", cyc - e.acc, LAT);
        check("stall_in_done", {31'b0, bus.stall}, 32'h0);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e, input bit push);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Funct3 = f;
    bus.SrcA   = a;
    bus.SrcB   = b;
    #1;
    check("stall_req", {31'b0, bus.stall}, 32'h1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.SrcA  = ~a;  // later operand changes must be ignored
    bus.SrcB  = ~b;
    if (push) q.push_back('{e, cyc});
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    check("drain_timeout", q.size(), 32'h0);
  endtask

  logic [W-1:0] last_res;
  int           acc1;

  initial begin
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.Funct3 = 3'b000;
    bus.SrcA   = '0;
    bus.SrcB   = '0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_busy",   {31'b0, bus.busy},  32'h0);
    check("rst_done",   {31'b0, bus.done},  32'h0);
    check("rst_stall",  {31'b0, bus.stall}, 32'h0);
    check("rst_result", bus.Result,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
      @(negedge clk);
      check("busy_prep", {31'b0, bus.busy},  32'h1);
      check("stall_run", {31'b0, bus.stall}, 32'h1);
      drain();
    end
    last_res = vecs[14].e;

    // Flush during CALC cycle 10: CALC starts after the 2nd edge counting acceptance
    issue(3'b101, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy",   {31'b0, bus.busy},  32'h0);
    check("flush_stall",  {31'b0, bus.stall}, 32'h0);
    check("flush_result", bus.Result,         last_res);
    repeat (W + 8) @(posedge clk);

    // start together with flush in IDLE is refused
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", {31'b0, bus.busy}, 32'h0);

    // Asynchronous reset in the middle of CALC
    issue(3'b000, 32'd3, 32'd4, 32'd0, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",   {31'b0, bus.busy},  32'h0);
    check("arst_done",   {31'b0, bus.done},  32'h0);
    check("arst_stall",  {31'b0, bus.stall}, 32'h0);
    check("arst_result", bus.Result,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 8) @(posedge clk);

    // start held across DONE: second op accepted in the IDLE cycle after DONE
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'd3;
    bus.SrcB   = 32'd5;
    @(posedge clk);
    #1;
    acc1 = cyc;
    q.push_back('{32'd15, acc1});
    bus.Funct3 = 3'b101;
    bus.SrcA   = 32'd100;
    bus.SrcB   = 32'd7;
    q.push_back('{32'd14, acc1 + LAT + 2});
    repeat (LAT + 2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();
    repeat (W + 8) @(posedge clk);
    check("final_queue", q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
